// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Shares the single register-file write port (we3/a3/wd3) between NREQ
// writeback requesters, and keeps a per-register pending-write scoreboard
// that raises stall when a decode source register still awaits its write.
//
// Handshake: on each requester a transfer happens on a rising clk edge when
// req_valid[i] and req_ready[i] are both high. req_ready is combinational,
// one-hot or zero, and only ever raised on a requester whose valid is high.
// A requester that is not granted holds valid/addr/data stable until it is.
//
// Optional feature macro: WB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration with a rotating priority pointer
//   undefined -> fixed priority, lowest requester index wins (no pointer)
//
// Register 15 is the PC: writes to it are accepted but dropped (r15_err
// pulses for one cycle), issues to it are ignored, and it never stalls.
`timescale 1ns/1ps

module regfile_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_addr,
    input  logic [DW*NREQ-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                issue_valid,
    input  logic [3:0]          issue_addr,
    input  logic [3:0]          a1,
    input  logic [3:0]          a2,
    output logic                stall,
    output logic                we3,
    output logic [3:0]          a3,
    output logic [DW-1:0]       wd3,
    output logic                r15_err
);

    localparam logic [3:0] PC_REG = 4'hF;

    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [3:0]      sel_addr;
    logic [DW-1:0]   sel_data;
    logic [15:0]     busy;
    logic [15:0]     busy_nxt;

`ifdef WB_ROUND_ROBIN_EN
    // Width of a requester index (NREQ is 2..4)
    localparam int IW = (NREQ > 2) ? 2 : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;

    // Rotating priority: search requesters ptr..NREQ-1 first, then 0..ptr-1
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == '0 && req_valid[i] && IW'(i) >= ptr) begin
                grant[i] = 1'b1;
                gnt_idx  = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant == '0 && req_valid[i] && IW'(i) < ptr) begin
                grant[i] = 1'b1;
                gnt_idx  = IW'(i);
            end
        end
    end

    // Pointer moves just past the requester that transferred; holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            if (gnt_idx == IW'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end
`else
    // Fixed priority: the lowest-indexed valid requester wins
    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == '0 && req_valid[i]) begin
                grant[i] = 1'b1;
            end
        end
    end
`endif

    // Grant is only raised on a valid requester, so any grant is a transfer
    assign req_ready = grant;
    assign xfer      = |grant;

    // Select the destination and data of the granted requester
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[4*i +: 4];
                sel_data = req_data[DW*i +: DW];
            end
        end
    end

    // Scoreboard next state: clear on writeback, then set on issue so that a
    // newer producer issued on the same edge keeps the register pending
    always_comb begin
        busy_nxt = busy;
        if (xfer && sel_addr != PC_REG) begin
            busy_nxt[sel_addr] = 1'b0;
        end
        if (issue_valid && issue_addr != PC_REG) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    // Scoreboard register; reset cancels every pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Stall on a pending write to either source; the PC never stalls and the
    // same-cycle writeback is not bypassed
    assign stall = (busy[a1] && a1 != PC_REG) || (busy[a2] && a2 != PC_REG);

    // Registered write port: one cycle after a transfer; PC writes are dropped
    // and flagged instead, and a3/wd3 simply hold while we3 is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3     <= 1'b0;
            a3      <= '0;
            wd3     <= '0;
            r15_err <= 1'b0;
        end else if (xfer) begin
            if (sel_addr != PC_REG) begin
                we3     <= 1'b1;
                a3      <= sel_addr;
                wd3     <= sel_data;
                r15_err <= 1'b0;
            end else begin
                we3     <= 1'b0;
                r15_err <= 1'b1;
            end
        end else begin
            we3     <= 1'b0;
            r15_err <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port (WE3/A3/WD3) between NREQ writeback requesters (ALU, load unit, multiplier).
- Uses a valid/ready handshake on each requester side.
- Keeps a per-register pending-write scoreboard and raises STALL when a decode-stage source register has an outstanding write.
- Sits between the execute/memory stages and the register file; the register-file write port is driven only by this block.

Parameters:
- NREQ, 3, number of writeback requesters (2..4).
- DW, 32, data width of WD3.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ_VALID  input  NREQ  per-requester write request valid.
- REQ_ADDR  input  4*NREQ  per-requester destination register; requester i uses bits [4i+3:4i].
- REQ_DATA  input  DW*NREQ  per-requester write data; requester i uses bits [DW*i+DW-1:DW*i].
- REQ_READY  output  NREQ  per-requester grant; combinational, one-hot or zero.
- ISSUE_VALID  input  1  decode issued an instruction that will write ISSUE_ADDR.
- ISSUE_ADDR  input  4  destination register of the issued instruction.
- A1  input  4  decode source register 1.
- A2  input  4  decode source register 2.
- STALL  output  1  source operand has a pending write; combinational.
- WE3  output  1  register-file write enable; registered.
- A3  output  4  register-file write address; registered.
- WD3  output  DW  register-file write data; registered.
- R15_ERR  output  1  one-cycle pulse: a write to register 15 was dropped.

Behaviour:
- Reset (RST_N low, asynchronous):
  - WE3=0, A3=0, WD3=0, R15_ERR=0, busy[15:0]=0.
  - Round-robin pointer set so requester 0 has highest priority.
- Arbitration (combinational):
  - Among asserted REQ_VALID bits, exactly one REQ_READY is raised, chosen from priority order starting at ptr.
  - No valid request: REQ_READY=0.
- Transfer: occurs on a rising edge when REQ_VALID[i] and REQ_READY[i] are both high.
- Pointer update: after a transfer from requester g, ptr=(g+1) mod NREQ. With no transfer, ptr holds.
- Write output timing:
  - The cycle after a transfer with addr!=15: WE3=1, A3=addr, WD3=data. Latency is 1 cycle.
  - Outputs are stable before the falling edge on which the register file writes.
  - WE3 deasserts in any cycle after a cycle with no transfer.
- R15 protection:
  - A granted request with addr=15 still completes its handshake (READY high) but produces no write: WE3=0 next cycle.
  - R15_ERR=1 for that next cycle.
- Throughput: one write per cycle, no bubbles. Requesters not granted hold VALID/ADDR/DATA stable until they are granted.
- Scoreboard:
  - ISSUE_VALID with ISSUE_ADDR!=15 sets busy[ISSUE_ADDR] on the rising edge.
  - A transfer to addr clears busy[addr] on the same edge.
  - Set and clear of the same address on the same edge: set wins, because a newer producer is pending.
  - ISSUE_ADDR=15 is ignored.
- STALL = (busy[A1] & A1!=15) | (busy[A2] & A2!=15).
  - Register 15 never stalls, since the PC is supplied separately.
  - STALL does not look at the same-cycle transfer (no bypass). It drops the cycle after the clearing edge.
- Reset mid-operation:
  - All busy bits clear and any in-flight WE3 is cancelled immediately (asynchronous).
  - Requests held across reset are re-arbitrated from requester 0.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration with the rotating pointer, as described above.
- Undefined: fixed priority, lowest requester index wins. The pointer register is not built. All other behaviour is identical.

Test Plan:
- Reset: hold RST_N=0 with REQ_VALID=3'b111 -> WE3=0, STALL=0, busy all zero. Release reset -> REQ_READY=3'b001 in the first cycle.
- Single write: REQ_VALID[1]=1, addr=5, data=32'hDEADBEEF, one cycle -> READY[1]=1; next cycle WE3=1, A3=5, WD3=32'hDEADBEEF; the cycle after, WE3=0.
- Contention (round-robin): all three valid continuously with addrs 1/2/3 -> grants 0,1,2,0 on consecutive cycles; A3 sequence 1,2,3,1 with WE3 high every cycle. Without WB_ROUND_ROBIN_EN -> requester 0 granted every cycle.
- R15 drop: requester 2 writes addr=15, data=32'h1234 -> READY[2]=1; next cycle WE3=0 and R15_ERR=1 for exactly one cycle.
- Scoreboard:
  - ISSUE_VALID with ISSUE_ADDR=7, then A1=7 -> STALL=1.
  - Requester 0 writes addr 7 -> STALL=0 from the cycle after the transfer.
  - Issue of 7 on the same edge as a write to 7 -> STALL remains 1.
- Async reset mid-stream: RST_N pulled low between clock edges while WE3=1 and busy[4]=1 -> WE3=0 and STALL=0 immediately, without waiting for a clock edge.
